// File: rtl/pulse_generator_mc_if.sv
// pulse_generator_mc_if
//   Bundles the configuration, control and status signals of the
//   multi-channel pulse generator. The master side (the controller)
//   drives ena, cfg_*, start and stop. The slave side (the generator)
//   drives out, busy and done.
//   Parameters: N  = period / burst-count width
//               CH = number of channels
//               CW = channel-select width
interface pulse_generator_mc_if #(
  parameter int N  = 8,
  parameter int CH = 4,
  parameter int CW = (CH > 1) ? $clog2(CH) : 1
) ();
  logic          ena;
  logic          cfg_wr;
  logic [CW-1:0] cfg_ch;
  logic [1:0]    cfg_mode;
  logic [N-1:0]  cfg_ticks;
  logic [N-1:0]  cfg_count;
  logic [CH-1:0] start;
  logic [CH-1:0] stop;
  logic [CH-1:0] out;
  logic [CH-1:0] busy;
  logic [CH-1:0] done;

  modport master (
    output ena, cfg_wr, cfg_ch, cfg_mode, cfg_ticks, cfg_count, start, stop,
    input  out, busy, done
  );

  modport slave (
    input  ena, cfg_wr, cfg_ch, cfg_mode, cfg_ticks, cfg_count, start, stop,
    output out, busy, done
  );
endinterface

// File: rtl/pulse_generator_mc.sv
// pulse_generator_mc
//   CH independent channels. Each channel emits one-cycle pulses on its
//   own programmable period, in one of three modes: PERIODIC
//   (free-running), ONESHOT (single delayed pulse) or BURST (fixed
//   number of pulses).
//   Ports:
//     clk   - system clock, all state updates on the rising edge
//     rst_n - asynchronous active-low reset
//     bus   - slave modport of pulse_generator_mc_if:
//               ena       global count enable
//               cfg_wr    configuration write strobe
//               cfg_ch    channel selected by cfg_wr
//               cfg_mode  0 OFF, 1 PERIODIC, 2 ONESHOT, 3 BURST
//               cfg_ticks period in cycles (0 means 2^N)
//               cfg_count BURST pulse count (0 treated as 1)
//               start     per-channel start or restart strobe
//               stop      per-channel stop strobe
//               out       per-channel one-cycle pulse (registered)
//               busy      channel running (registered)
//               done      final pulse of ONESHOT/BURST (registered)
module pulse_generator_mc #(
  parameter int N  = 8,
  parameter int CH = 4,
  parameter int CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pulse_generator_mc_if.slave  bus
);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_ONESHOT  = 2'd2,
    MODE_BURST    = 2'd3
  } mode_e;

  state_e       state_q [CH];
  state_e       state_d [CH];
  mode_e        mode_q  [CH];
  mode_e        mode_d  [CH];
  logic [N-1:0] ticks_q [CH];
  logic [N-1:0] ticks_d [CH];
  logic [N-1:0] count_q [CH];
  logic [N-1:0] count_d [CH];
  logic [N-1:0] cnt_q   [CH];
  logic [N-1:0] cnt_d   [CH];
  logic [N-1:0] rem_q   [CH];
  logic [N-1:0] rem_d   [CH];
  logic [CH-1:0] out_q, out_d;
  logic [CH-1:0] busy_q, busy_d;
  logic [CH-1:0] done_q, done_d;

  // Next-state logic for every channel. The if/else chain encodes the
  // event priority: cfg write, then stop, then start, then counting.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      state_d[i] = state_q[i];
      mode_d[i]  = mode_q[i];
      ticks_d[i] = ticks_q[i];
      count_d[i] = count_q[i];
      cnt_d[i]   = cnt_q[i];
      rem_d[i]   = rem_q[i];
      out_d[i]   = 1'b0;
      done_d[i]  = 1'b0;
      busy_d[i]  = 1'b0;

      if (bus.cfg_wr && (bus.cfg_ch == CW'(i))) begin
        mode_d[i]  = mode_e'(bus.cfg_mode);
        ticks_d[i] = bus.cfg_ticks;
        count_d[i] = bus.cfg_count;
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
      end else if (bus.stop[i]) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
      end else if (bus.start[i]) begin
        if (mode_q[i] != MODE_OFF) begin
          state_d[i] = ST_RUN;
          cnt_d[i]   = '0;
          // ONESHOT behaves as a burst of one; a zero count means one.
          if ((mode_q[i] == MODE_BURST) && (count_q[i] != '0)) begin
            rem_d[i] = count_q[i];
          end else begin
            rem_d[i] = N'(1);
          end
        end
      end else if ((state_q[i] == ST_RUN) && bus.ena) begin
        // ticks-1 wraps in N bits, so ticks=0 yields a 2^N period.
        if (cnt_q[i] == (ticks_q[i] - N'(1))) begin
          cnt_d[i] = '0;
          out_d[i] = 1'b1;
          if (mode_q[i] != MODE_PERIODIC) begin
            rem_d[i] = rem_q[i] - N'(1);
            if (rem_q[i] == N'(1)) begin
              done_d[i]  = 1'b1;
              state_d[i] = ST_IDLE;
            end
          end
        end else begin
          cnt_d[i] = cnt_q[i] + N'(1);
        end
      end

      // The final pulse keeps busy high for its own cycle so that busy
      // drops one edge after the last out/done.
      busy_d[i] = (state_d[i] == ST_RUN) || done_d[i];
    end
  end

  // State registers for all channels, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= ST_IDLE;
        mode_q[i]  <= MODE_OFF;
        ticks_q[i] <= '0;
        count_q[i] <= '0;
        cnt_q[i]   <= '0;
        rem_q[i]   <= '0;
      end
      out_q  <= '0;
      busy_q <= '0;
      done_q <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
        mode_q[i]  <= mode_d[i];
        ticks_q[i] <= ticks_d[i];
        count_q[i] <= count_d[i];
        cnt_q[i]   <= cnt_d[i];
        rem_q[i]   <= rem_d[i];
      end
      out_q  <= out_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
